ext_bus_fabric: RTL and testbench

Parametrised external-SRAM-bus fabric between the AVR core's sram_* master port and NUM_CH slave peripherals (IDE interface, future CD-DSP/subcode blocks). Decodes a region of the CPU data space into equal per-channel windows. Registers strobes toward the selected slave and inserts a configurable minimum number of wait states. Provides a timeout watchdog with a sticky error report, replacing the previous single point-to-point CPU-to-IDE hookup.

---
 rtl/ext_bus_fabric.sv | 205 ++++++++++++++++++++
 tb/tb_ext_bus_fabric.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_bus_fabric.sv
// ext_bus_fabric
//   Bridges the CPU external-SRAM master port to NUM_CH slave peripherals.
//   The CPU data space region starting at REGION_BASE is split into
//   equal 2**CH_LSB byte windows, one per channel. An access to a mapped
//   window is registered toward the selected slave, held for at least
//   MIN_WAIT+1 cycles and until the slave drops its wait request, or
//   abandoned after TIMEOUT_CYC cycles with a sticky error.
//
// Ports
//   clk, nrst           clock, asynchronous active-low reset
//   cpu_a, cpu_d_in     CPU address / write data
//   cpu_cs/oe/we        CPU select, read strobe, write strobe
//   cpu_d_out           read data to CPU (all ones unless an access is done)
//   cpu_wait            stall request to CPU (combinational)
//   ch_a, ch_d_out      registered address / write data, shared by slaves
//   ch_cs               registered one-hot slave select
//   ch_oe, ch_we        registered read / write strobes, shared
//   ch_d_in             slave read data, channel k at [k*DATA_W +: DATA_W]
//   ch_wait             per-slave wait request
//   err, err_ch, err_clr  sticky timeout flag, channel of last timeout, clear
module ext_bus_fabric #(
    parameter int                NUM_CH      = 4,
    parameter int                ADDR_W      = 16,
    parameter int                DATA_W      = 8,
    parameter int                CH_LSB      = 8,
    parameter logic [ADDR_W-1:0] REGION_BASE = 16'h8000,
    parameter int                MIN_WAIT    = 1,
    parameter int                TIMEOUT_CYC = 255,
    localparam int               CH_BITS     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic [ADDR_W-1:0]        cpu_a,
    input  logic [DATA_W-1:0]        cpu_d_in,
    output logic [DATA_W-1:0]        cpu_d_out,
    input  logic                     cpu_cs,
    input  logic                     cpu_oe,
    input  logic                     cpu_we,
    output logic                     cpu_wait,
    output logic [ADDR_W-1:0]        ch_a,
    output logic [DATA_W-1:0]        ch_d_out,
    output logic [NUM_CH-1:0]        ch_cs,
    output logic                     ch_oe,
    output logic                     ch_we,
    input  logic [NUM_CH*DATA_W-1:0] ch_d_in,
    input  logic [NUM_CH-1:0]        ch_wait,
    output logic                     err,
    output logic [CH_BITS-1:0]       err_ch,
    input  logic                     err_clr
);

    localparam int HI_LSB = CH_LSB + CH_BITS;
    localparam int CNT_W  = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_WAIT);
    localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t             state, next_state;
    logic [CH_BITS-1:0] sel;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  rdata;

    logic               req, in_region, idx_ok, hit;
    logic [CH_BITS-1:0] idx;
    logic               sel_wait;
    logic [DATA_W-1:0]  slave_rd [NUM_CH];
    logic               start, complete, timeout, abort;

    // ---------------- address decode ----------------
    assign req       = cpu_cs & (cpu_oe | cpu_we);
    assign in_region = (cpu_a[ADDR_W-1:HI_LSB] == REGION_BASE[ADDR_W-1:HI_LSB]);
    assign idx       = cpu_a[CH_LSB +: CH_BITS];

    // With a power-of-two channel count every index is mapped; otherwise the
    // top windows of the region are holes that are silently ignored.
    generate
        if (NUM_CH == (1 << CH_BITS)) begin : g_full
            assign idx_ok = 1'b1;
        end else begin : g_holes
            localparam logic [CH_BITS:0] NUM_CH_L = (CH_BITS + 1)'(NUM_CH);
            assign idx_ok = ({1'b0, idx} < NUM_CH_L);
        end
    endgenerate

    assign hit = req & in_region & idx_ok;

    // ---------------- selected slave view ----------------
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            slave_rd[k] = ch_d_in[k*DATA_W +: DATA_W];
        end
    end

    assign sel_wait = ch_wait[sel];

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values, independent of block order.
            state <= next_state;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a value unassigned, which would otherwise infer a latch.
        next_state = state;
        start      = 1'b0;
        complete   = 1'b0;
        timeout    = 1'b0;
        abort      = 1'b0;
        cpu_wait   = 1'b0;
        case (state)
            IDLE: begin
                if (hit) begin
                    start      = 1'b1;
                    cpu_wait   = 1'b1;
                    next_state = ACCESS;
                end
            end
            ACCESS: begin
                cpu_wait = 1'b1;
                // A CPU that gives up takes precedence over any slave outcome.
                if (!req) begin
                    abort      = 1'b1;
                    next_state = IDLE;
                end else if (!sel_wait && cnt >= CNT_MIN) begin
                    complete   = 1'b1;
                    next_state = DONE;
                end else if (sel_wait && cnt == CNT_TO) begin
                    timeout    = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                // Hold until the CPU releases so back-to-back accesses are
                // always separated by at least one IDLE cycle.
                if (!req) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    // NOTE: all datapath registers are plain flops (no storage arrays), so
    // they are all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sel      <= '0;
            cnt      <= '0;
            ch_a     <= '0;
            ch_d_out <= '0;
            ch_cs    <= '0;
            ch_oe    <= 1'b0;
            ch_we    <= 1'b0;
            rdata    <= '1;
        end else begin
            if (start) begin
                sel      <= idx;
                ch_a     <= cpu_a;
                ch_d_out <= cpu_d_in;
                ch_cs    <= NUM_CH'(1) << idx;
                ch_oe    <= cpu_oe;
                ch_we    <= cpu_we & ~cpu_oe;  // read wins if both strobes set
                cnt      <= '0;
            end else if (state == ACCESS && cnt != {CNT_W{1'b1}}) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (complete || timeout || abort) begin
                ch_cs <= '0;
                ch_oe <= 1'b0;
                ch_we <= 1'b0;
            end

            if (complete && ch_oe) begin
                rdata <= slave_rd[sel];
            end else if (timeout) begin
                rdata <= '1;
            end
        end
    end

    // ---------------- error reporting ----------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            err    <= 1'b0;
            err_ch <= '0;
        end else begin
            if (timeout) begin
                err    <= 1'b1;  // a new timeout beats a simultaneous clear
                err_ch <= sel;
            end else if (err_clr) begin
                err    <= 1'b0;
            end
        end
    end

    assign cpu_d_out = (state == DONE) ? rdata : '1;

endmodule

// File: tb/tb_ext_bus_fabric.sv
// Self-checking bench for ext_bus_fabric (NUM_CH=4, 256-byte windows at
// 16'h8000, MIN_WAIT=1, TIMEOUT_CYC=255). Inputs change 1 time unit after
// the rising edge; outputs are checked 3 units later, mid-cycle.
module tb_ext_bus_fabric;

    localparam int NUM_CH      = 4;
    localparam int MIN_WAIT    = 1;
    localparam int TIMEOUT_CYC = 255;
    localparam int BASE        = 16'h8000;
    localparam int WIN         = 256;

    logic        clk = 1'b0;
    logic        nrst;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_d_in, cpu_d_out;
    logic        cpu_cs, cpu_oe, cpu_we, cpu_wait;
    logic [15:0] ch_a;
    logic [7:0]  ch_d_out;
    logic [3:0]  ch_cs;
    logic        ch_oe, ch_we;
    logic [31:0] ch_d_in;
    logic [3:0]  ch_wait;
    logic        err;
    logic [1:0]  err_ch;
    logic        err_clr;

    ext_bus_fabric #(
        .NUM_CH(NUM_CH), .MIN_WAIT(MIN_WAIT), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .nrst(nrst),
        .cpu_a(cpu_a), .cpu_d_in(cpu_d_in), .cpu_d_out(cpu_d_out),
        .cpu_cs(cpu_cs), .cpu_oe(cpu_oe), .cpu_we(cpu_we), .cpu_wait(cpu_wait),
        .ch_a(ch_a), .ch_d_out(ch_d_out), .ch_cs(ch_cs),
        .ch_oe(ch_oe), .ch_we(ch_we),
        .ch_d_in(ch_d_in), .ch_wait(ch_wait),
        .err(err), .err_ch(err_ch), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic set_bus(input logic [15:0] a, input logic [7:0] d,
                           input logic cs, input logic oe, input logic we);
        cpu_a    = a;
        cpu_d_in = d;
        cpu_cs   = cs;
        cpu_oe   = oe;
        cpu_we   = we;
    endtask

    task automatic idle_bus();
        cpu_cs = 1'b0;
        cpu_oe = 1'b0;
        cpu_we = 1'b0;
    endtask

    // Counts cycles with cpu_wait high, starting from the current cycle.
    task automatic count_stall(output int n);
        n = 0;
        settle();
        while (cpu_wait && n <= 400) begin
            n++;
            tick();
            settle();
        end
    endtask

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        logic        cs, oe, we;
        logic        exp_wait;
        logic [3:0]  exp_cs;
        logic        exp_oe, exp_we;
    } vec_t;

    vec_t vecs [11];

    // Reference model state: last value the fabric returned, error report.
    logic [7:0] m_rdata;
    logic       m_err;
    logic [1:0] m_err_ch;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [15:0] a;
        logic [7:0]  d, exp_d;
        logic        cs, oe, we, hit, stuck;
        int          w, ch, exp_n;
        logic [31:0] dvec;

        vecs[0]  = '{16'h8000, 8'h11, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0001, 1'b1, 1'b0};
        vecs[1]  = '{16'h81FF, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0010, 1'b0, 1'b1};
        vecs[2]  = '{16'h82AB, 8'h33, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0100, 1'b1, 1'b0};
        vecs[3]  = '{16'h83FF, 8'h44, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1000, 1'b0, 1'b1};
        vecs[4]  = '{16'h8300, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};
        vecs[5]  = '{16'h8200, 8'h66, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};
        vecs[6]  = '{16'h8400, 8'h77, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};
        vecs[7]  = '{16'h0100, 8'h88, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};
        vecs[8]  = '{16'h7FFF, 8'h99, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0};
        vecs[9]  = '{16'hFC00, 8'hAA, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};
        vecs[10] = '{16'h8700, 8'hBB, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0};

        // ---------------- reset values ----------------
        nrst    = 1'b0;
        err_clr = 1'b0;
        ch_wait = 4'b0000;
        ch_d_in = 32'h0;
        set_bus(16'h0, 8'h0, 1'b0, 1'b0, 1'b0);
        #2;
        check("rst_cs",    ch_cs,     4'b0000);
        check("rst_oe_we", {ch_oe, ch_we}, 2'b00);
        check("rst_a",     ch_a,      16'h0);
        check("rst_dout",  cpu_d_out, 8'hFF);
        check("rst_err",   {err, err_ch}, 3'b000);
        check("rst_wait",  cpu_wait,  1'b0);
        tick();
        settle();
        nrst = 1'b1;
        tick();

        // ---------------- table: decode, latching, abort ----------------
        ch_wait = 4'hF;
        for (int i = 0; i < 11; i++) begin
            set_bus(vecs[i].a, vecs[i].d, vecs[i].cs, vecs[i].oe, vecs[i].we);
            settle();
            check($sformatf("tbl%0d_hit_wait", i), cpu_wait, vecs[i].exp_wait);
            tick();
            settle();
            check($sformatf("tbl%0d_cs", i), ch_cs, vecs[i].exp_cs);
            if (vecs[i].exp_wait) begin
                check($sformatf("tbl%0d_a", i), ch_a, vecs[i].a);
                check($sformatf("tbl%0d_dout", i), ch_d_out, vecs[i].d);
                check($sformatf("tbl%0d_oe_we", i), {ch_oe, ch_we}, {vecs[i].exp_oe, vecs[i].exp_we});
            end
            check($sformatf("tbl%0d_acc_wait", i), cpu_wait, vecs[i].exp_wait);
            idle_bus();
            tick();
            settle();
            check($sformatf("tbl%0d_after_cs", i), ch_cs, 4'b0000);
            check($sformatf("tbl%0d_after_str", i), {ch_oe, ch_we, cpu_wait}, 3'b000);
            check($sformatf("tbl%0d_after_dout", i), cpu_d_out, 8'hFF);
            check($sformatf("tbl%0d_after_err", i), err, 1'b0);
            tick();
        end

        // ---------------- read ch2, no slave wait ----------------
        ch_wait = 4'b0000;
        ch_d_in = 32'h11A5_2233;
        set_bus(16'h8234, 8'h00, 1'b1, 1'b1, 1'b0);
        settle();
        check("rd2_hit_wait", cpu_wait, 1'b1);
        check("rd2_hit_cs", ch_cs, 4'b0000);
        tick(); settle();
        check("rd2_cs", ch_cs, 4'b0100);
        check("rd2_a", ch_a, 16'h8234);
        check("rd2_acc0_wait", cpu_wait, 1'b1);
        tick(); settle();
        check("rd2_acc1_wait", cpu_wait, 1'b1);
        tick(); settle();
        check("rd2_done_wait", cpu_wait, 1'b0);
        check("rd2_done_data", cpu_d_out, 8'hA5);
        check("rd2_done_cs", ch_cs, 4'b0000);
        idle_bus();
        tick(); settle();
        check("rd2_idle_data", cpu_d_out, 8'hFF);
        tick();

        // ---------------- write ch0, slave holds wait 10 cycles ----------------
        ch_wait = 4'b0001;
        set_bus(16'h8012, 8'h3C, 1'b1, 1'b0, 1'b1);
        settle();
        check("wr0_hit_wait", cpu_wait, 1'b1);
        tick();
        for (int i = 0; i < 10; i++) begin
            settle();
            check($sformatf("wr0_acc%0d", i), {cpu_wait, ch_we, ch_oe, ch_cs, ch_d_out},
                  {1'b1, 1'b1, 1'b0, 4'b0001, 8'h3C});
            tick();
        end
        ch_wait = 4'b0000;
        settle();
        check("wr0_fall_wait", cpu_wait, 1'b1);
        check("wr0_fall_we", ch_we, 1'b1);
        tick(); settle();
        check("wr0_done_wait", cpu_wait, 1'b0);
        check("wr0_done_we", ch_we, 1'b0);
        check("wr0_err", err, 1'b0);
        idle_bus();
        tick();

        // ---------------- ch1 stuck: timeout ----------------
        // ACCESS counts 0..TIMEOUT_CYC; the timeout fires in the cycle the
        // count reaches TIMEOUT_CYC, so the stall is 1 + (TIMEOUT_CYC+1).
        ch_wait = 4'b0010;
        set_bus(16'h8155, 8'h00, 1'b1, 1'b1, 1'b0);
        count_stall(n);
        check("to1_stall", n, TIMEOUT_CYC + 2);
        check("to1_data", cpu_d_out, 8'hFF);
        check("to1_err", err, 1'b1);
        check("to1_err_ch", err_ch, 2'd1);
        check("to1_cs", ch_cs, 4'b0000);
        idle_bus();
        ch_wait = 4'b0000;
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        settle();
        check("to1_clr_err", err, 1'b0);
        check("to1_clr_err_ch", err_ch, 2'd1);
        tick();

        // ---------------- timeout on ch3 with err_clr held high ----------------
        ch_wait = 4'b1000;
        err_clr = 1'b1;
        set_bus(16'h83C0, 8'h00, 1'b1, 1'b1, 1'b0);
        count_stall(n);
        err_clr = 1'b0;
        check("to3_stall", n, TIMEOUT_CYC + 2);
        check("to3_err_set_wins", err, 1'b1);
        check("to3_err_ch", err_ch, 2'd3);
        idle_bus();
        ch_wait = 4'b0000;
        tick();

        // ---------------- abort mid-ACCESS, then async reset mid-ACCESS ----------------
        ch_wait = 4'b0100;
        set_bus(16'h8210, 8'h5E, 1'b1, 1'b0, 1'b1);
        tick(); tick(); tick();
        settle();
        check("ab_acc_we", {ch_we, ch_cs}, {1'b1, 4'b0100});
        idle_bus();
        tick(); settle();
        check("ab_idle", {cpu_wait, ch_we, ch_oe, ch_cs}, 7'b0);
        check("ab_err_kept", err, 1'b1);
        tick();

        ch_wait = 4'b1000;
        set_bus(16'h8301, 8'hC3, 1'b1, 1'b1, 1'b0);
        tick(); tick();
        settle();
        check("rst_acc_cs", ch_cs, 4'b1000);
        nrst = 1'b0;
        idle_bus();
        #1;
        check("arst_cs", ch_cs, 4'b0000);
        check("arst_str", {ch_oe, ch_we}, 2'b00);
        check("arst_a", ch_a, 16'h0);
        check("arst_dout", ch_d_out, 8'h0);
        check("arst_cpu_dout", cpu_d_out, 8'hFF);
        check("arst_err", {err, err_ch}, 3'b000);
        check("arst_wait", cpu_wait, 1'b0);
        tick();
        nrst = 1'b1;
        ch_wait = 4'b0000;
        tick();

        // ---------------- randomized transactions vs model ----------------
        m_rdata  = 8'hFF;
        m_err    = 1'b0;
        m_err_ch = 2'd0;
        for (int t = 0; t < 200; t++) begin
            if ($urandom_range(0, 9) < 6) a = 16'(BASE + $urandom_range(0, NUM_CH*WIN - 1));
            else                          a = 16'($urandom);
            d     = 8'($urandom);
            cs    = ($urandom_range(0, 7) != 0);
            oe    = 1'($urandom_range(0, 1));
            we    = 1'($urandom_range(0, 1));
            w     = $urandom_range(0, 12);
            stuck = ($urandom_range(0, 39) == 0);
            dvec  = $urandom;
            hit   = cs && (oe || we) && (int'(a) >= BASE) && (int'(a) < BASE + NUM_CH*WIN);
            ch    = hit ? (int'(a) - BASE) / WIN : 0;

            ch_d_in = dvec;
            ch_wait = 4'($urandom);
            set_bus(a, d, cs, oe, we);
            n = 0;
            settle();
            while (cpu_wait && n <= 400) begin
                n++;
                tick();
                ch_wait = 4'($urandom);
                if (hit) ch_wait[ch] = stuck || (n - 1 < w);
                settle();
                if (n == 1 && hit) check("rnd_cs", ch_cs, 4'b0001 << ch);
            end

            if (!hit)       exp_n = 0;
            else if (stuck) exp_n = TIMEOUT_CYC + 2;
            else            exp_n = ((w > MIN_WAIT) ? w : MIN_WAIT) + 2;

            if (hit) begin
                if (stuck) begin
                    m_rdata  = 8'hFF;
                    m_err    = 1'b1;
                    m_err_ch = 2'(ch);
                end else if (oe) begin
                    m_rdata = dvec[ch*8 +: 8];
                end
            end
            exp_d = hit ? m_rdata : 8'hFF;

            check($sformatf("rnd%0d_stall", t), n, exp_n);
            check($sformatf("rnd%0d_data", t), cpu_d_out, exp_d);
            check($sformatf("rnd%0d_err", t), {err, err_ch}, {m_err, m_err_ch});
            check($sformatf("rnd%0d_strobes", t), {ch_cs, ch_oe, ch_we}, 6'b0);

            idle_bus();
            if ($urandom_range(0, 3) == 0) begin
                err_clr = 1'b1;
                m_err   = 1'b0;
            end
            tick();
            err_clr = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
